// File: rtl/alu_arb_pkg.sv
// Shared types and defaults for the two-requester ALU arbiter.
package alu_arb_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef logic arb_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: favours the requester that did not win last.
module rr_arb2
  import alu_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  arb_id_t other_s;

  assign other_s = ~last_grant;

  // Winner selection; falls back to the previous winner when it is alone
  always_comb begin
    gnt    = 2'b00;
    gnt_id = other_s;
    if (req[other_s]) begin
      gnt[other_s] = 1'b1;
      gnt_id       = other_s;
    end else if (req[last_grant]) begin
      gnt[last_grant] = 1'b1;
      gnt_id          = last_grant;
    end else begin
      gnt    = 2'b00;
      gnt_id = other_s;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external add/zero ALU between two requesters, one op in flight.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic              req_sel0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  input  logic              req_sel1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_out,
  output logic              rsp_zero,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_select,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
`endif
);

  arb_state_e        state_r;
  arb_state_e        state_nxt_s;
  arb_id_t           last_grant_r;
  arb_id_t           id_r;
  logic [1:0]        gnt_s;
  logic              gnt_id_s;
  logic              accept_s;
  logic [DATA_W-1:0] op_a_s;
  logic [DATA_W-1:0] op_b_s;
  logic              op_sel_s;

  rr_arb2 u_rr_arb2 (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .gnt        (gnt_s),
    .gnt_id     (gnt_id_s)
  );

  // Operand steering from the current winner
  always_comb begin
    op_a_s   = req_a0;
    op_b_s   = req_b0;
    op_sel_s = req_sel0;
    if (gnt_id_s) begin
      op_a_s   = req_a1;
      op_b_s   = req_b1;
      op_sel_s = req_sel1;
    end else begin
      op_a_s   = req_a0;
      op_b_s   = req_b0;
      op_sel_s = req_sel0;
    end
  end

  // Next state and the combinational accept handshake (IDLE only)
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    req_ready   = 2'b00;
    case (state_r)
      IDLE: begin
        // req_ready is held low while reset is asserted
        if (rst_n && (req_valid != 2'b00)) begin
          req_ready   = gnt_s;
          accept_s    = 1'b1;
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: state_nxt_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM, operand issue, result capture and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      id_r         <= 1'b0;
      alu_a        <= {DATA_W{1'b0}};
      alu_b        <= {DATA_W{1'b0}};
      alu_select   <= 1'b0;
      rsp_out      <= {DATA_W{1'b0}};
      rsp_zero     <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_valid    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      rsp_valid <= (state_nxt_s == RESP);
      busy      <= (state_nxt_s != IDLE);
      if (accept_s) begin
        alu_a        <= op_a_s;
        alu_b        <= op_b_s;
        alu_select   <= op_sel_s;
        id_r         <= gnt_id_s;
        last_grant_r <= gnt_id_s;
      end
      if (state_r == EXEC) begin
        rsp_out  <= alu_out;
        rsp_zero <= alu_zero;
        rsp_id   <= id_r;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;

  // Saturating acceptance counters per requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_r <= {CNT_W{1'b0}};
      cnt1_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      if (!gnt_id_s) begin
        if (cnt0_r != {CNT_W{1'b1}}) cnt0_r <= cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        if (cnt1_r != {CNT_W{1'b1}}) cnt1_r <= cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign grant_cnt0 = cnt0_r;
  assign grant_cnt1 = cnt1_r;
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 4-bit add/zero ALU datapath between two independent requesters.
- Round-robin arbitration; one operation in flight at a time.
- Drives the ALU operand/select inputs from registers and captures its Out/Zero result.
- Returns the result to the winning requester over a valid/ready response channel tagged with the requester id.

Parameters:
DATA_W, 4, operand/result width; must match ALU width
CNT_W, 8, grant counter width (used only with optional feature)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  request valid, bit i = requester i
req_ready  out  2  request accept, one-hot or zero
req_a0, req_b0  in  DATA_W each  requester 0 operands
req_sel0  in  1  requester 0 SELECT (1 = add, 0 = force zero)
req_a1, req_b1  in  DATA_W each  requester 1 operands
req_sel1  in  1  requester 1 SELECT
rsp_valid  out  1  result valid
rsp_ready  in  1  result accept
rsp_id  out  1  requester id of result
rsp_out  out  DATA_W  captured ALU Out
rsp_zero  out  1  captured ALU Zero
alu_a, alu_b  out  DATA_W each  to ALU A/B
alu_select  out  1  to ALU SELECT
alu_out  in  DATA_W  from ALU Out
alu_zero  in  1  from ALU Zero
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; last_grant=1, so requester 0 wins first. Asserting reset mid-operation discards the in-flight op; no response is issued.
- FSM states IDLE, EXEC, RESP:
  - IDLE:
    - If any req_valid, pick winner g: the requester other than last_grant if it is valid, else the only valid one.
    - req_ready[g]=1 combinationally (only in IDLE, only the winner).
    - On req_valid[g] & req_ready[g], register a/b/sel into alu_a/alu_b/alu_select, set id=g and last_grant=g, go to EXEC.
    - With no valid request, stay in IDLE with req_ready=0.
  - EXEC (1 cycle): the ALU is combinational. Capture alu_out→rsp_out, alu_zero→rsp_zero, id→rsp_id. Go to RESP.
  - RESP: rsp_valid=1, with rsp_out/rsp_zero/rsp_id held stable. When rsp_ready=1, go to IDLE; rsp_valid drops the next cycle. rsp_ready may be high on the first RESP cycle, giving a single-cycle response.
- Latency: accept edge to rsp_valid = 2 cycles. Minimum issue interval is 3 cycles. No new request is accepted in EXEC or RESP.
- alu_a/alu_b/alu_select hold their last issued values outside EXEC.
- Arithmetic belongs to the ALU: sum wraps mod 2^DATA_W with no carry out. SELECT=0 gives Out=0 and Zero=1. The block passes results through unmodified.
- Requester withdrawal: a requester may drop req_valid before acceptance. Arbitration is re-evaluated every IDLE cycle, and last_grant changes only on acceptance.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1, each CNT_W bits.
  - Each counts accepted requests for its requester and saturates at all-ones.
  - Reset value 0.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package alu_arb_pkg:
  - DATA_W and CNT_W defaults
  - state enum type {IDLE, EXEC, RESP}
  - requester id type (1 bit)
- Sub-module rr_arb2: 2-way round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: gnt one-hot, gnt_id.
  - Purely combinational.
- The top holds the FSM, operand/result registers and optional counters.

Test Plan:
- Single op: req0 a=3, b=4, sel=1, rsp_ready=1. Expect req_ready[0] in the same cycle, rsp_valid 2 cycles later with rsp_out=7, rsp_zero=0, rsp_id=0.
- Wrap and zero: req1 a=9, b=7, sel=1 → rsp_out=0, rsp_zero=1. Then a=9, b=8 → rsp_out=1. Then sel=0, a=5, b=5 → rsp_out=0, rsp_zero=1.
- Fairness: both requesters continuously valid, 6 ops → rsp_id sequence 0,1,0,1,0,1. Each req_ready is a single-cycle pulse, and never both set.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid and data stay stable and req_ready stays 0. On rsp_ready=1 → IDLE next cycle.
- Reset mid-op: assert rst_n=0 during EXEC → all outputs 0 immediately, no rsp_valid afterward. The next simultaneous request is granted to requester 0.
- With ALU_ARB_STATS_EN and CNT_W=2: 5 grants to requester 0 → grant_cnt0=3 (saturated), grant_cnt1 unchanged.
